m_stage_bus_master: RTL and testbench

Memory-stage access unit of the pipelined MIPS core, sitting directly downstream of the EX/MEM pipeline register. It consumes the registered memory-stage controls (ALU result as address, store data, store/load flags, size/sign control, upstream exception flag). It then performs one load or store per instruction over a req/ack system bus to data memory and the two timers. Its outputs are the extended load data and AdEL/AdES exceptions, and it holds the front of the pipeline until the bus access completes.

---
 rtl/m_stage_bus_master_if.sv | 22 ++
 rtl/m_stage_bus_master.sv | 197 +++++++++++++++++++
 tb/tb_m_stage_bus_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_stage_bus_master_if.sv
// Request/acknowledge system bus between the memory-stage access unit and
// data memory / timers. The master drives the request side, the slave
// returns the acknowledge and read word.
interface m_stage_bus_master_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/m_stage_bus_master.sv
// Memory-stage access unit: address checks, one bus access per load/store,
// lane steering for stores and alignment/extension for loads. Holds the
// front of the pipeline while an access is outstanding.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no access in flight; checks faults, may launch an access
//   ST_REQ  | request held on the bus until ack
//   ST_DONE | access finished; load data presented, pipeline advances
module m_stage_bus_master (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 i_addr,
  input  logic [31:0]                 i_wdata,
  input  logic                        i_store,
  input  logic                        i_load,
  input  logic [2:0]                  i_sl_ctrl,
  input  logic                        i_exc_in,
  input  logic [4:0]                  i_exc_code_in,
  input  logic                        i_exc_clr,
  m_stage_bus_master_if.master        bus,
  output logic                        o_stall,
  output logic [31:0]                 o_rdata,
  output logic                        o_rdata_valid,
  output logic                        o_exc_get,
  output logic [4:0]                  o_exc_code
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_sl_ctrl;
  logic [1:0]  r_lo;
  logic        r_abort;
  logic [31:0] r_rword;

  logic        w_is_half;
  logic        w_is_byte;
  logic        w_is_word;
  logic        w_op;
  logic        w_in_dm;
  logic        w_in_tc;
  logic        w_misalign;
  logic        w_fault;
  logic        w_launch;
  logic        w_abort;
  logic [3:0]  w_be_st;
  logic [31:0] w_wdata_st;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Access size decode; unused encodings behave as word accesses.
  assign w_is_half = (i_sl_ctrl == 3'b001) || (i_sl_ctrl == 3'b010);
  assign w_is_byte = (i_sl_ctrl == 3'b011) || (i_sl_ctrl == 3'b100);
  assign w_is_word = ~w_is_half & ~w_is_byte;

  // A store wins when both flags are set, so i_store alone picks direction.
  assign w_op = (i_store | i_load) & ~i_exc_in;

  assign w_in_dm = (i_addr <= 32'h0000_2FFF);
  assign w_in_tc = ((i_addr >= 32'h0000_7F00) && (i_addr <= 32'h0000_7F0B)) ||
                   ((i_addr >= 32'h0000_7F10) && (i_addr <= 32'h0000_7F1B));

  assign w_misalign = (w_is_word & (i_addr[1:0] != 2'b00)) | (w_is_half & i_addr[0]);

  // Timers are word-only and their count register (offset 8) is read-only.
  assign w_fault = w_op & (w_misalign |
                           ~(w_in_dm | w_in_tc) |
                           (w_in_tc & ~w_is_word) |
                           (i_store & w_in_tc & (i_addr[3:0] == 4'h8)));

  assign w_launch = (r_state == ST_IDLE) & w_op & ~w_fault & ~i_exc_clr;

  // A flush arriving on the ack cycle itself must also abort.
  assign w_abort = r_abort | i_exc_clr;

  // Store lane steering: enables follow the address, data is replicated.
  always_comb begin
    w_be_st    = 4'b1111;
    w_wdata_st = i_wdata;
    if (w_is_half) begin
      w_be_st    = i_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata_st = {2{i_wdata[15:0]}};
    end else if (w_is_byte) begin
      w_be_st    = 4'b0001 << i_addr[1:0];
      w_wdata_st = {4{i_wdata[7:0]}};
    end
  end

  // State register plus registered bus outputs and captured read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'h0;
      r_be      <= 4'h0;
      r_wdata   <= 32'h0;
      r_sl_ctrl <= 3'b000;
      r_lo      <= 2'b00;
      r_abort   <= 1'b0;
      r_rword   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_req     <= 1'b1;
        r_we      <= i_store;
        r_addr    <= {i_addr[31:2], 2'b00};
        r_be      <= i_store ? w_be_st : 4'b0000;
        r_wdata   <= w_wdata_st;
        r_sl_ctrl <= i_sl_ctrl;
        r_lo      <= i_addr[1:0];
        r_abort   <= 1'b0;
      end else if (r_state == ST_REQ) begin
        if (i_exc_clr) begin
          r_abort <= 1'b1;
        end
        if (bus.ack) begin
          r_req   <= 1'b0;
          r_rword <= bus.rdata;
        end
      end
    end
  end

  // Next-state, stall, exception and load-valid decode.
  always_comb begin
    w_state_nxt   = r_state;
    o_stall       = 1'b0;
    o_exc_get     = 1'b0;
    o_exc_code    = 5'd0;
    o_rdata_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_exc_in) begin
          o_exc_get  = 1'b1;
          o_exc_code = i_exc_code_in;
        end else if (w_fault) begin
          o_exc_get  = 1'b1;
          o_exc_code = i_store ? 5'd5 : 5'd4;
        end
        if (w_launch) begin
          w_state_nxt = ST_REQ;
          o_stall     = 1'b1;
        end
      end
      ST_REQ: begin
        o_stall = 1'b1;
        if (bus.ack) begin
          if (w_abort) begin
            w_state_nxt = ST_IDLE;
            o_stall     = 1'b0;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt   = ST_IDLE;
        o_rdata_valid = ~r_we;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load alignment and extension from the captured word.
  always_comb begin
    w_half = r_lo[1] ? r_rword[31:16] : r_rword[15:0];
    case (r_lo)
      2'd0:    w_byte = r_rword[7:0];
      2'd1:    w_byte = r_rword[15:8];
      2'd2:    w_byte = r_rword[23:16];
      default: w_byte = r_rword[31:24];
    endcase
    case (r_sl_ctrl)
      3'b001:  o_rdata = {{16{w_half[15]}}, w_half};
      3'b010:  o_rdata = {16'h0, w_half};
      3'b011:  o_rdata = {{24{w_byte[7]}}, w_byte};
      3'b100:  o_rdata = {24'h0, w_byte};
      default: o_rdata = r_rword;
    endcase
  end

  assign bus.req   = r_req;
  assign bus.we    = r_we;
  assign bus.addr  = r_addr;
  assign bus.be    = r_be;
  assign bus.wdata = r_wdata;

endmodule

// File: tb/tb_m_stage_bus_master.sv
// Bench for the memory-stage access unit: directed scenarios followed by
// random accesses, all checked against a byte-level reference model.
module tb_m_stage_bus_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_store = 1'b0;
  logic        i_load = 1'b0;
  logic [2:0]  i_sl_ctrl = '0;
  logic        i_exc_in = 1'b0;
  logic [4:0]  i_exc_code_in = '0;
  logic        i_exc_clr = 1'b0;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        o_exc_get;
  logic [4:0]  o_exc_code;

  int checks = 0;
  int errors = 0;

  m_stage_bus_master_if bus_if ();

  m_stage_bus_master dut (
    .clk           (clk),
    .reset         (reset),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .i_store       (i_store),
    .i_load        (i_load),
    .i_sl_ctrl     (i_sl_ctrl),
    .i_exc_in      (i_exc_in),
    .i_exc_code_in (i_exc_code_in),
    .i_exc_clr     (i_exc_clr),
    .bus           (bus_if),
    .o_stall       (o_stall),
    .o_rdata       (o_rdata),
    .o_rdata_valid (o_rdata_valid),
    .o_exc_get     (o_exc_get),
    .o_exc_code    (o_exc_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] c);
    if (c == 3'd1 || c == 3'd2) return 2;
    if (c == 3'd3 || c == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit m_fault(input bit st, input logic [31:0] a, input logic [2:0] c);
    int  n  = m_size(c);
    bit  dm = (a <= 32'h2FFF);
    bit  tc = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
    if ((a & 32'(n - 1)) != 0) return 1;
    if (!(dm || tc)) return 1;
    if (tc && n != 4) return 1;
    if (st && tc && (a & 32'hF) == 32'h8) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] c);
    int n = m_size(c);
    int first = int'(a & 32'h3);
    logic [3:0] be = '0;
    for (int lane = 0; lane < 4; lane++)
      be[lane] = (lane >= first) && (lane < first + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [2:0] c);
    int n = m_size(c);
    if (n == 2) return 32'(w & 32'hFFFF) * 32'h0001_0001;
    if (n == 1) return 32'(w & 32'hFF) * 32'h0101_0101;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                         input logic [2:0] c);
    int n = m_size(c);
    int bits = 8 * n;
    logic [31:0] mask;
    logic [31:0] v;
    if (n == 4) return word;
    mask = (32'd1 << bits) - 32'd1;
    v = (word >> (8 * int'(a & 32'h3))) & mask;
    if ((c == 3'd1 || c == 3'd3) && ((v >> (bits - 1)) & 32'd1) == 32'd1)
      v = v | ~mask;
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    i_store = 1'b0; i_load = 1'b0; i_exc_in = 1'b0; i_exc_clr = 1'b0;
  endtask

  // One instruction presented in IDLE; runs the bus side with 'waits'
  // stall cycles before ack and checks every observable output.
  task automatic run_op(input string tag, input bit st, input bit ld, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] w, input bit ei,
                        input logic [4:0] ec, input logic [31:0] rd, input int waits);
    bit valid;
    bit flt;
    i_store = st; i_load = ld; i_sl_ctrl = c; i_addr = a; i_wdata = w;
    i_exc_in = ei; i_exc_code_in = ec; i_exc_clr = 1'b0;
    #1;
    valid = (st || ld) && !ei;
    flt = valid && m_fault(st, a, c);
    if (ei) begin
      chk({tag, " exc_get"}, 32'(o_exc_get), 32'd1);
      chk({tag, " exc_code"}, 32'(o_exc_code), 32'(ec));
      chk({tag, " stall"}, 32'(o_stall), 32'd0);
    end else if (flt) begin
      chk({tag, " exc_get"}, 32'(o_exc_get), 32'd1);
      chk({tag, " exc_code"}, 32'(o_exc_code), st ? 32'd5 : 32'd4);
      chk({tag, " stall"}, 32'(o_stall), 32'd0);
    end else begin
      chk({tag, " exc_get"}, 32'(o_exc_get), 32'd0);
      chk({tag, " stall"}, 32'(o_stall), valid ? 32'd1 : 32'd0);
    end
    step();
    if (!valid || flt) begin
      chk({tag, " no req"}, 32'(bus_if.req), 32'd0);
      chk({tag, " no stall"}, 32'(o_stall), 32'd0);
      clear_ops();
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      chk({tag, " req"}, 32'(bus_if.req), 32'd1);
      chk({tag, " we"}, 32'(bus_if.we), 32'(st));
      chk({tag, " addr"}, bus_if.addr, a & 32'hFFFF_FFFC);
      chk({tag, " be"}, 32'(bus_if.be), st ? 32'(m_be(a, c)) : 32'd0);
      if (st) chk({tag, " wdata"}, bus_if.wdata, m_wdata(w, c));
      chk({tag, " req stall"}, 32'(o_stall), 32'd1);
      chk({tag, " req exc"}, 32'(o_exc_get), 32'd0);
      if (i == waits) begin
        bus_if.ack = 1'b1;
        bus_if.rdata = rd;
      end
      step();
    end
    bus_if.ack = 1'b0;
    bus_if.rdata = $urandom;
    chk({tag, " done stall"}, 32'(o_stall), 32'd0);
    chk({tag, " done req"}, 32'(bus_if.req), 32'd0);
    chk({tag, " done valid"}, 32'(o_rdata_valid), st ? 32'd0 : 32'd1);
    if (!st) chk({tag, " rdata"}, o_rdata, m_load(rd, a, c));
    step();
    clear_ops();
    #1;
    chk({tag, " idle req"}, 32'(bus_if.req), 32'd0);
    chk({tag, " idle valid"}, 32'(o_rdata_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [2:0]  c;
    bit          st;
    bit          ld;
    bus_if.ack = 1'b0;
    bus_if.rdata = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst req", 32'(bus_if.req), 32'd0);
    chk("rst we", 32'(bus_if.we), 32'd0);
    chk("rst addr", bus_if.addr, 32'd0);
    chk("rst be", 32'(bus_if.be), 32'd0);
    chk("rst wdata", bus_if.wdata, 32'd0);
    chk("rst stall", 32'(o_stall), 32'd0);
    chk("rst rdata", o_rdata, 32'd0);
    chk("rst valid", 32'(o_rdata_valid), 32'd0);
    chk("rst exc", 32'(o_exc_get), 32'd0);
    chk("rst code", 32'(o_exc_code), 32'd0);

    run_op("lw",      0, 1, 3'd0, 32'h10,   32'h0,  0, 5'd0, 32'h8765_4321, 0);
    run_op("sb",      1, 0, 3'd4, 32'h103,  32'hAB, 0, 5'd0, 32'h0,         0);
    run_op("lb",      0, 1, 3'd3, 32'h103,  32'h0,  0, 5'd0, 32'hAB00_0000, 0);
    run_op("lbu",     0, 1, 3'd4, 32'h103,  32'h0,  0, 5'd0, 32'hAB00_0000, 1);
    run_op("lh",      0, 1, 3'd1, 32'h2,    32'h0,  0, 5'd0, 32'h8001_1234, 3);
    run_op("sh",      1, 0, 3'd2, 32'h2FFE, 32'h1234_5678, 0, 5'd0, 32'h0, 2);
    run_op("sw tc1",  1, 1, 3'd0, 32'h7F10, 32'hCAFE_F00D, 0, 5'd0, 32'h0, 0);
    run_op("lw tc0c", 0, 1, 3'd0, 32'h7F08, 32'h0,  0, 5'd0, 32'h0000_0042, 1);
    run_op("f sw mis",1, 0, 3'd0, 32'h6,    32'h0,  0, 5'd0, 32'h0, 0);
    run_op("f lh tc", 0, 1, 3'd1, 32'h7F00, 32'h0,  0, 5'd0, 32'h0, 0);
    run_op("f sw cnt",1, 0, 3'd0, 32'h7F08, 32'h0,  0, 5'd0, 32'h0, 0);
    run_op("f lw oom",0, 1, 3'd0, 32'h3000, 32'h0,  0, 5'd0, 32'h0, 0);
    run_op("exc in",  1, 0, 3'd0, 32'h20,   32'h0,  1, 5'd10, 32'h0, 0);

    // flush while idle suppresses the launch
    i_load = 1'b1; i_sl_ctrl = 3'd0; i_addr = 32'h10; i_exc_clr = 1'b1;
    #1;
    chk("clr idle stall", 32'(o_stall), 32'd0);
    step();
    chk("clr idle req", 32'(bus_if.req), 32'd0);
    clear_ops();

    // flush during REQ: access completes, no DONE, no load data
    i_load = 1'b1; i_sl_ctrl = 3'd0; i_addr = 32'h20;
    #1;
    chk("abort launch stall", 32'(o_stall), 32'd1);
    step();
    i_exc_clr = 1'b1;
    #1;
    chk("abort req", 32'(bus_if.req), 32'd1);
    chk("abort req stall", 32'(o_stall), 32'd1);
    step();
    i_exc_clr = 1'b0;
    chk("abort wait req", 32'(bus_if.req), 32'd1);
    chk("abort wait valid", 32'(o_rdata_valid), 32'd0);
    step();
    bus_if.ack = 1'b1; bus_if.rdata = 32'h1111_2222;
    #1;
    chk("abort ack stall", 32'(o_stall), 32'd0);
    chk("abort ack valid", 32'(o_rdata_valid), 32'd0);
    step();
    bus_if.ack = 1'b0;
    clear_ops();
    #1;
    chk("abort idle req", 32'(bus_if.req), 32'd0);
    chk("abort idle valid", 32'(o_rdata_valid), 32'd0);
    chk("abort idle stall", 32'(o_stall), 32'd0);
    step();
    chk("abort stays idle", 32'(bus_if.req), 32'd0);

    // reset while a request is outstanding
    i_store = 1'b1; i_sl_ctrl = 3'd0; i_addr = 32'h40; i_wdata = 32'hDEAD_BEEF;
    step();
    chk("rreq req", 32'(bus_if.req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_ops();
    #1;
    chk("rreq req0", 32'(bus_if.req), 32'd0);
    chk("rreq we0", 32'(bus_if.we), 32'd0);
    chk("rreq addr0", bus_if.addr, 32'd0);
    chk("rreq be0", 32'(bus_if.be), 32'd0);
    chk("rreq wdata0", bus_if.wdata, 32'd0);
    chk("rreq stall0", 32'(o_stall), 32'd0);
    chk("rreq valid0", 32'(o_rdata_valid), 32'd0);
    chk("rreq rdata0", o_rdata, 32'd0);
    step();
    chk("rreq idle", 32'(bus_if.req), 32'd0);

    // random accesses
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 32'h2FFF));
        2:       a = 32'h7F00 + 32'($urandom_range(0, 31));
        default: a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(32'h3000, 32'h7EFF)) : $urandom;
      endcase
      c  = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 2) == 0);
      ld = ($urandom_range(0, 3) != 0);
      run_op("rand", st, ld, c, a, $urandom, ($urandom_range(0, 7) == 0),
             5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
